// File: rtl/iot_pkg.sv
// Shared constants for the IoT device event encoder.
// Pure declarations; no timing or flow control.
package iot_pkg;

   localparam int   N_DEV_DEFAULT = 8;
   localparam logic EVT_ON        = 1'b1;
   localparam logic EVT_OFF       = 1'b0;
   localparam int   CNT_W         = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick of the lowest pending index at or above ptr, wrapping.
// Combinational, zero latency; the caller owns the pointer and any enable gating.
module rr_arbiter
   import iot_pkg::*;
#(
   parameter int N     = N_DEV_DEFAULT,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             vld
);

   logic [N-1:0] hi_req;
   logic [N-1:0] pick;

   always_comb begin
      hi_req = req & ({N{1'b1}} << ptr);
      // Nothing at or above the pointer means the search wraps to index 0.
      pick   = (|hi_req) ? hi_req : req;
      grant  = pick & (-pick);
      vld    = |req;
   end

endmodule

// File: rtl/iot_event_encoder.sv
// Per-device connect/disconnect edge queue serialised to change/on_off, round-robin.
// Edge to change pulse is two edges; enable=0 holds events pending with no loss.
module iot_event_encoder
   import iot_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_DEV-1:0] dev_active,
   input  logic             enable,
   output logic             change,
   output logic             on_off,
   output logic [CNT_W-1:0] active_cnt,
   output logic [CNT_W-1:0] pend_cnt,
   output logic             busy
);

   localparam int PTR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

   logic [N_DEV-1:0] prev_q, prev_d;
   logic [N_DEV-1:0] pend_on_q, pend_on_d;
   logic [N_DEV-1:0] pend_off_q, pend_off_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic             change_q, change_d;
   logic             on_off_q, on_off_d;
   logic [CNT_W-1:0] active_cnt_q, active_cnt_d;
   logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
   logic             busy_q, busy_d;

   logic [N_DEV-1:0] rise, fall, pend_any, pend_nxt;
   logic [N_DEV-1:0] grant_raw, grant;
   logic             arb_vld, emit;
   logic [PTR_W-1:0] sel;

   assign pend_any = pend_on_q | pend_off_q;

   rr_arbiter #(.N(N_DEV), .PTR_W(PTR_W)) u_arb (
      .req   (pend_any),
      .ptr   (rr_ptr_q),
      .grant (grant_raw),
      .vld   (arb_vld)
   );

   always_comb begin
      rise   = dev_active & ~prev_q;
      fall   = ~dev_active & prev_q;
      prev_d = dev_active;
      grant  = enable ? grant_raw : '0;
      emit   = enable & arb_vld;

      sel = '0;
      for (int i = 0; i < N_DEV; i++) begin
         if (grant[i]) sel = PTR_W'(i);
      end

      // Emitted bit clears first, so a same-cycle opposite edge queues a fresh event.
      pend_on_d  = pend_on_q & ~grant;
      pend_off_d = pend_off_q & ~grant;
      for (int i = 0; i < N_DEV; i++) begin
         if (rise[i]) begin
            if (pend_off_d[i]) pend_off_d[i] = 1'b0;
            else               pend_on_d[i]  = 1'b1;
         end
         if (fall[i]) begin
            if (pend_on_d[i]) pend_on_d[i]  = 1'b0;
            else              pend_off_d[i] = 1'b1;
         end
      end
      pend_nxt = pend_on_d | pend_off_d;

      change_d     = emit;
      on_off_d     = on_off_q;
      active_cnt_d = active_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      if (emit) begin
         on_off_d     = (|(pend_on_q & grant)) ? EVT_ON : EVT_OFF;
         active_cnt_d = (on_off_d == EVT_ON) ? active_cnt_q + CNT_W'(1)
                                             : active_cnt_q - CNT_W'(1);
         rr_ptr_d     = (sel == PTR_W'(N_DEV - 1)) ? '0 : sel + PTR_W'(1);
      end

      pend_cnt_d = '0;
      for (int i = 0; i < N_DEV; i++) begin
         pend_cnt_d = pend_cnt_d + CNT_W'(pend_nxt[i]);
      end
      busy_d = (pend_cnt_d != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q       <= '0;
         pend_on_q    <= '0;
         pend_off_q   <= '0;
         rr_ptr_q     <= '0;
         change_q     <= 1'b0;
         on_off_q     <= 1'b0;
         active_cnt_q <= '0;
         pend_cnt_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         pend_on_q    <= pend_on_d;
         pend_off_q   <= pend_off_d;
         rr_ptr_q     <= rr_ptr_d;
         change_q     <= change_d;
         on_off_q     <= on_off_d;
         active_cnt_q <= active_cnt_d;
         pend_cnt_q   <= pend_cnt_d;
         busy_q       <= busy_d;
      end
   end

   // Offs only follow emitted ons, so the count can never wrap in a correct design.
   always @(posedge clk) begin
      if (!rst && emit) begin
         a_cnt_no_wrap: assert (on_off_d == EVT_ON ? active_cnt_q != CNT_W'(N_DEV)
                                                   : active_cnt_q != '0);
      end
   end

   assign change     = change_q;
   assign on_off     = on_off_q;
   assign active_cnt = active_cnt_q;
   assign pend_cnt   = pend_cnt_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_iot_event_encoder.sv
// Directed vector table for iot_event_encoder plus an asynchronous mid-reset sequence.
module tb_iot_event_encoder;

   logic       clk;
   logic       rst;
   logic [7:0] dev_active;
   logic       enable;
   logic       change;
   logic       on_off;
   logic [7:0] active_cnt;
   logic [7:0] pend_cnt;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] dev;
      logic       en;
      logic       rs;
      logic       chg;
      logic       on;
      logic [7:0] acnt;
      logic [7:0] pcnt;
      logic       bsy;
   } vec_t;

   vec_t tbl[$];

   iot_event_encoder #(.N_DEV(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .dev_active (dev_active),
      .enable     (enable),
      .change     (change),
      .on_off     (on_off),
      .active_cnt (active_cnt),
      .pend_cnt   (pend_cnt),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic [7:0] dev, input logic en, input logic rs, input logic chg,
                      input logic on, input logic [7:0] acnt, input logic [7:0] pcnt, input logic bsy);
      vec_t v;
      v.dev = dev; v.en = en; v.rs = rs; v.chg = chg;
      v.on = on; v.acnt = acnt; v.pcnt = pcnt; v.bsy = bsy;
      tbl.push_back(v);
   endtask

   initial begin
      // Release with all lines high: eight ons drain in index order.
      add(8'hFF, 1, 0, 0, 0, 0, 8, 1);
      for (int k = 1; k <= 8; k++)
         add(8'hFF, 1, 0, 1, 1, 8'(k), 8'(8 - k), (k != 8));
      add(8'hFF, 1, 0, 0, 1, 8, 0, 0);
      // Reset back to idle.
      add(8'h00, 1, 1, 0, 0, 0, 0, 0);
      add(8'h00, 1, 0, 0, 0, 0, 0, 0);
      // Single device 3 up then down.
      add(8'h08, 1, 0, 0, 0, 0, 1, 1);
      add(8'h08, 1, 0, 1, 1, 1, 0, 0);
      add(8'h00, 1, 0, 0, 1, 1, 1, 1);
      add(8'h00, 1, 0, 1, 0, 0, 0, 0);
      // Round robin: dev2 on, dev5 on, then dev2 falls with dev6 rising; dev6 wins.
      add(8'h04, 1, 0, 0, 0, 0, 1, 1);
      add(8'h04, 1, 0, 1, 1, 1, 0, 0);
      add(8'h24, 1, 0, 0, 1, 1, 1, 1);
      add(8'h24, 1, 0, 1, 1, 2, 0, 0);
      add(8'h60, 1, 0, 0, 1, 2, 2, 1);
      add(8'h60, 1, 0, 1, 1, 3, 1, 1);
      add(8'h60, 1, 0, 1, 0, 2, 0, 0);
      add(8'h60, 1, 0, 0, 0, 2, 0, 0);
      // Cancel: dev1 high for two cycles with emission held.
      add(8'h62, 0, 0, 0, 0, 2, 1, 1);
      add(8'h62, 0, 0, 0, 0, 2, 1, 1);
      add(8'h60, 0, 0, 0, 0, 2, 0, 0);
      add(8'h60, 1, 0, 0, 0, 2, 0, 0);
      // Backlog of four, then back-to-back drain.
      add(8'h7B, 0, 0, 0, 0, 2, 4, 1);
      add(8'h7B, 0, 0, 0, 0, 2, 4, 1);
      add(8'h7B, 1, 0, 1, 1, 3, 3, 1);
      add(8'h7B, 1, 0, 1, 1, 4, 2, 1);
      add(8'h7B, 1, 0, 1, 1, 5, 1, 1);
      add(8'h7B, 1, 0, 1, 1, 6, 0, 0);
      add(8'h7B, 1, 0, 0, 1, 6, 0, 0);
      // Emit of dev2 on coincides with its fall: off follows.
      add(8'h7F, 1, 0, 0, 1, 6, 1, 1);
      add(8'h7B, 1, 0, 1, 1, 7, 1, 1);
      add(8'h7B, 1, 0, 1, 0, 6, 0, 0);
      // Three pending events for the mid-reset sequence.
      add(8'hFE, 0, 0, 0, 0, 6, 3, 1);

      rst = 1'b1;
      dev_active = 8'hFF;
      enable = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_change", -1, {7'b0, change}, 8'h00);
      check("rst_active_cnt", -1, active_cnt, 8'h00);
      check("rst_busy", -1, {7'b0, busy}, 8'h00);
      check("rst_pend_cnt", -1, pend_cnt, 8'h00);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         dev_active = tbl[i].dev;
         enable     = tbl[i].en;
         rst        = tbl[i].rs;
         @(posedge clk);
         #1;
         check("change", i, {7'b0, change}, {7'b0, tbl[i].chg});
         check("on_off", i, {7'b0, on_off}, {7'b0, tbl[i].on});
         check("active_cnt", i, active_cnt, tbl[i].acnt);
         check("pend_cnt", i, pend_cnt, tbl[i].pcnt);
         check("busy", i, {7'b0, busy}, {7'b0, tbl[i].bsy});
      end

      // Asynchronous reset with three events pending.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mrst_change", -2, {7'b0, change}, 8'h00);
      check("mrst_on_off", -2, {7'b0, on_off}, 8'h00);
      check("mrst_active_cnt", -2, active_cnt, 8'h00);
      check("mrst_pend_cnt", -2, pend_cnt, 8'h00);
      check("mrst_busy", -2, {7'b0, busy}, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      dev_active = 8'h00;
      enable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check("post_rst_change", k, {7'b0, change}, 8'h00);
         check("post_rst_pend_cnt", k, pend_cnt, 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/iot_event_encoder.md
# iot_event_encoder

Event source for the active IoT devices monitor. It watches one activity line per device and detects connect and disconnect edges. Pending events are queued per device and serialised onto the monitor's `change` / `on_off` interface, at most one event per cycle, with round-robin fairness. A shadow count of devices already reported active lets the bench and system cross-check the monitor's `counter_out`.

## Interface
Parameters:
- `N_DEV`, default 8: number of devices; legal range 2..255.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `dev_active`  in  N_DEV: per-device activity level, synchronous to `clk`; 1 = device on.
- `enable`  in  1: 1 = emission allowed; 0 = events are held pending.
- `change`  out  1: registered; 1-cycle pulse per emitted event. Drives the monitor's `change` input.
- `on_off`  out  1: registered direction of the current event (1 = connect/up, 0 = disconnect/down). Drives the monitor's `on_off` input.
- `active_cnt`  out  8: registered count of connects minus disconnects emitted so far.
- `pend_cnt`  out  8: registered number of pending event bits.
- `busy`  out  1: registered; 1 while any event is pending.

## Operation
- `prev` register holds the last sampled `dev_active`.
  - rise[i] = dev_active[i] & ~prev[i]
  - fall[i] = ~dev_active[i] & prev[i]
- Each device has two pending bits, `pend_on[i]` and `pend_off[i]`. At most one of them is set at any time.
- Per-device update at each edge, applied in this order:
  1. Clear the bit emitted this cycle.
  2. Apply rise/fall: a rise with `pend_off[i]` set clears `pend_off[i]` (net zero). Otherwise a rise sets `pend_on[i]`. Falls mirror this.
- Arbiter:
  - If `enable`=1 and any bit is pending, select the lowest device index ≥ `rr_ptr` (wrapping) that has a pending bit.
  - Register `change`=1 and `on_off`=pend_on[sel].
  - Set `rr_ptr` ← (sel+1) mod N_DEV.
  - If nothing is selected, `change`=0 and `on_off` holds its last value.
- `active_cnt`: +1 on an emitted on, −1 on an emitted off. It stays within 0..N_DEV by construction. No saturation logic is required; a wrap is a design bug and is flagged by an assertion.
- `pend_cnt` = popcount(pend_on | pend_off) after the update. `busy` = (pend_cnt ≠ 0).
- `enable`=0: edges keep accumulating, `change`=0, `rr_ptr` frozen.

## Timing
- Reset values: `prev`=0, all pending bits 0, `rr_ptr`=0, `change`=0, `on_off`=0, `active_cnt`=0, `pend_cnt`=0, `busy`=0.
- Reset mid-operation clears all state immediately, including any pending events, which are dropped.
- Latency:
  - An edge on `dev_active` sampled at edge k sets its pending bit at edge k.
  - With `enable`=1 and no contention, `change` is high during the cycle after edge k+1.
  - `active_cnt` updates at the same edge that raises `change`.
- Throughput: one event per cycle. M simultaneous edges drain in M consecutive cycles with `change` held high.
- Simultaneous emit and new opposite edge on the same device: the emitted bit clears and the new edge sets the opposite bit. Two events result, both in order.
- Toggle on then off before emission: both cancel and no event is emitted.
- First cycle after reset release with lines already high: one on event per high line.

## Structure
- Package `iot_pkg`:
  - `N_DEV_DEFAULT`
  - `EVT_ON`=1'b1, `EVT_OFF`=1'b0
  - Count width constant `CNT_W`=8
- Sub-module `rr_arbiter`: pending mask plus pointer in, one-hot grant and valid out. Purely combinational select; the pointer lives in the parent.
- Top module: edge detection, pending bits, output registers, counters.

## Test plan
- Reset: hold `rst`=1 for 10 cycles with `dev_active`=8'hFF → `change`=0, `active_cnt`=0, `busy`=0. Release with `enable`=1 → 8 consecutive `change` pulses with `on_off`=1, devices 0..7 in order, then `active_cnt`=8.
- Single device: from idle, set `dev_active[3]`=1 → `change`=1 with `on_off`=1 exactly one cycle after the sampling edge. Clear it → one pulse with `on_off`=0; `active_cnt` returns to 0.
- Round robin: emit device 5, then make devices 2 and 6 rise together → order 6 then 2.
- Cancel: with `enable`=0, pulse `dev_active[1]` high for 2 cycles → `pend_cnt` goes 1 then 0. Raising `enable` produces no `change`.
- Backlog: with `enable`=0, raise 4 lines → `pend_cnt`=4, `busy`=1. Set `enable`=1 → 4 back-to-back pulses, then `pend_cnt`=0.
- Mid-reset: assert `rst` while 3 events are pending → all outputs are 0 within the same cycle, and no events are emitted after release until new edges occur.
- End-to-end check: instantiate alongside the monitor; `counter_out` must equal `active_cnt` in every cycle after reset.
